// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data has fixed priority; each access has a bounded wait with a sticky timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner_d;   // 1: load/store owns the port, 0: fetch
  logic [CNT_W-1:0] wait_cnt;

  assign dbg_state = state;

  // Handshake: a requester holds its request until its ready pulse; ready is
  // high for exactly one cycle (RESP) and rdata is valid during that cycle.
  assign stall_mem = (mem_read | mem_write) & ~mem_ready;
  assign stall_if  = (if_req & ~if_ready) | stall_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      wait_cnt    <= '0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_ready    <= 1'b0;
      mem_ready   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read | mem_write) begin
            state     <= BUSY;
            owner_d   <= 1'b1;
            wait_cnt  <= '0;
            ram_req   <= 1'b1;
            ram_we    <= mem_write;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (if_req) begin
            state     <= BUSY;
            owner_d   <= 1'b0;
            wait_cnt  <= '0;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
          end
        end
        BUSY: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (ram_ack) begin
            ram_req <= 1'b0;
            state   <= RESP;
            if (!ram_we) begin
              if (owner_d) mem_rdata <= ram_rdata;
              else         if_rdata  <= ram_rdata;
            end
            if (owner_d) mem_ready <= 1'b1;
            else         if_ready  <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            ram_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RESP;
            if (owner_d) begin
              mem_rdata <= '0;
              mem_ready <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_ready <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a short random sweep,
// read data checked through an expected-value queue per requester.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              ram_ack = 1'b0;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_if_q[$];
  logic [DATA_W-1:0] exp_mem_q[$];
  logic [DATA_W-1:0] if_model  = '0;
  logic [DATA_W-1:0] mem_model = '0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    if_model  = '0;
    mem_model = '0;
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    step();
  endtask

  // scoreboard: read data popped when a ready pulse appears
  always @(negedge clk) begin
    if (!reset && if_ready) begin
      if (exp_if_q.size() == 0) check("if_ready_unexpected", if_ready, 0);
      else check("if_rdata", if_rdata, exp_if_q.pop_front());
    end
    if (!reset && mem_ready) begin
      if (exp_mem_q.size() == 0) check("mem_ready_unexpected", mem_ready, 0);
      else check("mem_rdata", mem_rdata, exp_mem_q.pop_front());
    end
  end

  // driver: one access, ack in the dly-th BUSY cycle, optional stray ack in RESP
  task automatic run_single(input bit is_data, input bit we, input bit rd_too,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            input int dly, input logic [DATA_W-1:0] rdata, input bit stray);
    if (is_data) begin
      mem_read  = we ? rd_too : 1'b1;
      mem_write = we;
      mem_addr  = addr;
      mem_wdata = wdata;
      if (!we) mem_model = rdata;
      exp_mem_q.push_back(mem_model);
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
      if_model = rdata;
      exp_if_q.push_back(if_model);
    end
    @(negedge clk);
    check("req_stall_if", stall_if, 1);
    check("req_stall_mem", stall_mem, is_data);
    step();
    for (int i = 1; i <= dly; i++) begin
      ram_ack   = (i == dly);
      ram_rdata = rdata;
      @(negedge clk);
      check("busy_ram_req", ram_req, 1);
      check("busy_ram_addr", ram_addr, addr);
      check("busy_ram_we", ram_we, is_data & we);
      check("busy_ram_wdata", ram_wdata, is_data ? wdata : '0);
      check("busy_stall_if", stall_if, 1);
      step();
    end
    ram_ack   = stray;
    ram_rdata = ~rdata;
    @(negedge clk);
    check("resp_if_ready", if_ready, !is_data);
    check("resp_mem_ready", mem_ready, is_data);
    check("resp_ram_req", ram_req, 0);
    check("resp_stall_if", stall_if, 0);
    check("resp_stall_mem", stall_mem, 0);
    step();
    ram_ack   = 1'b0;
    if_req    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, 0);
    check("idle_ram_req", ram_req, 0);
    check("idle_if_ready", if_ready, 0);
    check("idle_mem_ready", mem_ready, 0);
    check("hold_if_rdata", if_rdata, if_model);
    check("hold_mem_rdata", mem_rdata, mem_model);
    step();
  endtask

  initial begin
    do_reset();

    // fetch only: ack at c2, ready at c3
    run_single(0, 0, 0, 32'h40, 32'h0, 2, 32'h2002000A, 0);

    // conflict: data served first, fetch granted after RESP
    mem_read = 1'b1; mem_addr = 32'h1000; if_req = 1'b1; if_addr = 32'h44;
    mem_model = 32'h1111_2222; if_model = 32'h3333_4444;
    exp_mem_q.push_back(mem_model);
    exp_if_q.push_back(if_model);
    @(negedge clk);
    check("cf_c0_stall_mem", stall_mem, 1);
    step();
    ram_ack = 1'b1; ram_rdata = 32'h1111_2222;
    @(negedge clk);
    check("cf_c1_addr", ram_addr, 32'h1000);
    check("cf_c1_we", ram_we, 0);
    step();
    ram_ack = 1'b0;
    @(negedge clk);
    check("cf_c2_mem_ready", mem_ready, 1);
    check("cf_c2_if_ready", if_ready, 0);
    check("cf_c2_stall_if", stall_if, 1);
    step();
    mem_read = 1'b0;
    @(negedge clk);
    check("cf_c3_state", dbg_state, 0);
    check("cf_c3_ram_req", ram_req, 0);
    check("cf_c3_stall_if", stall_if, 1);
    step();
    ram_ack = 1'b1; ram_rdata = 32'h3333_4444;
    @(negedge clk);
    check("cf_c4_ram_req", ram_req, 1);
    check("cf_c4_addr", ram_addr, 32'h44);
    step();
    ram_ack = 1'b0;
    @(negedge clk);
    check("cf_c5_if_ready", if_ready, 1);
    check("cf_c5_stall_if", stall_if, 0);
    step();
    if_req = 1'b0;
    step();

    // store leaves mem_rdata untouched; then stray ack in IDLE
    run_single(1, 1, 0, 32'h2000, 32'hDEADBEEF, 1, 32'hCAFE_F00D, 0);
    ram_ack = 1'b1; ram_rdata = 32'h7777_7777;
    step();
    ram_ack = 1'b0;
    @(negedge clk);
    check("stray_idle_if_ready", if_ready, 0);
    check("stray_idle_mem_ready", mem_ready, 0);
    check("stray_idle_mem_rdata", mem_rdata, mem_model);
    check("stray_idle_ram_req", ram_req, 0);
    step();

    // stray ack in RESP, then ack in the last allowed wait cycle
    run_single(0, 0, 0, 32'h48, 32'h0, 1, 32'h0BAD_0001, 1);
    run_single(1, 0, 0, 32'h2004, 32'h0, MAX_WAIT, 32'h55AA_55AA, 0);
    @(negedge clk);
    check("late_ack_no_timeout", timeout_err, 0);

    // random sweep
    for (int n = 0; n < 10; n++) begin
      bit is_data;
      bit we;
      is_data = 1'($urandom_range(0, 1));
      we = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
      run_single(is_data, we, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 int'($urandom_range(1, MAX_WAIT)), $urandom, 1'($urandom_range(0, 1)));
    end

    // timeout: ram_req high exactly MAX_WAIT cycles
    step();
    mem_read = 1'b1; mem_addr = 32'h3000;
    mem_model = '0;
    exp_mem_q.push_back(mem_model);
    step();
    for (int i = 1; i <= MAX_WAIT; i++) begin
      @(negedge clk);
      check("to_ram_req", ram_req, 1);
      check("to_err_low", timeout_err, 0);
      step();
    end
    @(negedge clk);
    check("to_ram_req_drop", ram_req, 0);
    check("to_mem_ready", mem_ready, 1);
    check("to_err_set", timeout_err, 1);
    step();
    mem_read = 1'b0;
    step();
    step();
    @(negedge clk);
    check("to_err_sticky", timeout_err, 1);
    check("to_state_idle", dbg_state, 0);
    step();

    // reset mid-access with an ack in the same cycle
    do_reset();
    mem_read = 1'b1; mem_addr = 32'h5000;
    step();
    step();
    reset = 1'b1; ram_ack = 1'b1; ram_rdata = 32'h9999_9999; mem_read = 1'b0;
    step();
    reset = 1'b0; ram_ack = 1'b0;
    @(negedge clk);
    check("rm_ram_req", ram_req, 0);
    check("rm_mem_ready", mem_ready, 0);
    check("rm_state", dbg_state, 0);
    check("rm_timeout", timeout_err, 0);
    check("rm_mem_rdata", mem_rdata, 0);
    step();
    step();

    check("if_q_drained", exp_if_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (loads/stores driven by the EX/MEM pipeline register).
- Arbitrates between the two requesters, sequences the memory request/acknowledge handshake with a bounded wait, returns read data to the winner, and produces the stall signals that freeze the pipeline registers while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MAX_WAIT, 15, maximum cycles ram_req may stay high without ram_ack before a timeout (must be >= 1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held stable until if_ready
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched instruction; valid while if_ready=1
- if_ready  output  1  one-cycle pulse: fetch complete
- mem_read  input  1  load request (EX/MEM MemRead); held until mem_ready
- mem_write  input  1  store request (EX/MEM MemWrite); held until mem_ready
- mem_addr  input  ADDR_W  load/store address (EX/MEM ALU result)
- mem_wdata  input  DATA_W  store data (EX/MEM write data)
- mem_rdata  output  DATA_W  load data; valid while mem_ready=1
- mem_ready  output  1  one-cycle pulse: load/store complete
- stall_if  output  1  freeze PC and IF/ID register
- stall_mem  output  1  freeze all pipeline registers up to and including EX/MEM
- ram_req  output  1  memory request, registered
- ram_we  output  1  1 = write, registered
- ram_addr  output  ADDR_W  registered
- ram_wdata  output  DATA_W  registered
- ram_rdata  input  DATA_W  memory read data; sampled when ram_ack=1
- ram_ack  input  1  memory completion; single-cycle
- timeout_err  output  1  sticky: an access timed out

Behaviour:
- States: IDLE, BUSY, RESP. An owner register holds D (data) or I (fetch).
- Reset (synchronous, high) forces the following on the next edge, including mid-access: state=IDLE; ram_req=ram_we=0; ram_addr=ram_wdata=0; if_rdata=mem_rdata=0; if_ready=mem_ready=0; timeout_err=0; wait counter=0. A pending ram_ack in that cycle is ignored.
- IDLE, data pending (mem_read|mem_write): go to BUSY with owner=D. Data has fixed priority over fetch. The edge also latches ram_addr=mem_addr, ram_wdata=mem_wdata, ram_we=mem_write (write wins if mem_read and mem_write are both high), and sets ram_req=1.
- IDLE, only if_req: same transition with owner=I, ram_addr=if_addr, ram_we=0, ram_wdata=0.
- BUSY: ram_req stays high and address/data stay frozen.
- BUSY, ram_ack=1:
  - Drop ram_req.
  - For a read, load ram_rdata into the owner's rdata register; for a write, rdata is unchanged.
  - Go to RESP.
- BUSY, no ack: the wait counter (cleared on BUSY entry) increments.
- BUSY, no ack, counter == MAX_WAIT-1:
  - Timeout: drop ram_req, set timeout_err, load the owner's rdata with 0, go to RESP.
  - ram_req is therefore high for at most MAX_WAIT cycles.
  - If ram_ack arrives in that same cycle, the ack wins and no timeout is raised.
- RESP: the owner's ready is 1 for exactly this cycle; the next state is IDLE unconditionally. No arbitration happens in RESP, so a request the pipeline is retiring on this edge is never re-granted.
- ram_ack outside BUSY is ignored.
- Latency: request seen in IDLE at cycle 0 -> ram_req at cycle 1 -> ack at cycle k>=1 -> ready at cycle k+1 -> IDLE at k+2.
- Stalls are combinational from current state and inputs:
  - stall_mem = (mem_read|mem_write) & ~mem_ready
  - stall_if = (if_req & ~if_ready) | stall_mem
- timeout_err stays at 1 until reset.
- The rdata registers hold their last value between accesses.
- Requesters changing address/data while not ready is a protocol violation; the arbiter uses the values latched at grant.

Test Plan:
- Fetch only: if_req=1, if_addr=0x40 at c0; ram_ack at c2 with ram_rdata=0x2002000A -> ram_req high c1-c2, ram_addr=0x40, ram_we=0, if_ready=1 at c3 with if_rdata=0x2002000A, stall_if=1 c0-c2 and 0 at c3.
- Conflict: mem_read(0x1000) and if_req(0x44) together, ack after 1 cycle -> data served first (mem_ready at c2, rdata=ram_rdata). Fetch is granted in IDLE at c3 (ram_req c4), if_ready at c5. stall_if stays high until c5.
- Store: mem_write=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF -> ram_we=1, ram_wdata=0xDEADBEEF, mem_ready pulse after ack; mem_rdata unchanged.
- Timeout: MAX_WAIT=4, mem_read, no ack -> ram_req high exactly 4 cycles, then mem_ready=1 with mem_rdata=0 and timeout_err=1, held afterwards. A variant with ack in the 4th cycle -> normal completion, timeout_err=0.
- Reset mid-access: reset=1 during BUSY with ram_ack=1 in the same cycle -> next cycle ram_req=0, no ready pulse, state IDLE, timeout_err=0.
- Stray ack: ram_ack=1 in IDLE and in RESP -> no ready pulse, rdata unchanged.
